uart_cmd_decoder: RTL and testbench
===================================

# uart_cmd_decoder

Receives 8N1 serial bytes on the board's RsRx line and turns single-character ASCII commands into one-cycle pulses equivalent to debounced button presses. It sits upstream of the air-conditioner control path: its `cmd_up`/`cmd_down`/`cmd_left`/`cmd_run`/`cmd_report` outputs are ORed with the debounced btnU/btnD/btnL/btnC/btnR pulses at the top level. It also exposes the raw received byte for logging.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD`, 9600: serial bit rate.
- `OVERSAMPLE`, 16: sample ticks per bit; must be even and ≥ 8.

- `clk`  in  1  system clock.
- `reset`  in  1  reset. Asynchronous and active-low; all state clears while low.
- `rx`  in  1  raw serial input, asynchronous to `clk`, idle high.
- `rx_data`  out  8  last received byte; holds its value until the next good frame.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples low, or on a parity error when parity is enabled.
- `cmd_up`, `cmd_down`, `cmd_left`, `cmd_run`, `cmd_report`  out  1 each  one-cycle command pulses.

## Operation
- `rx` passes through a 2-flop synchronizer whose flops reset to 1. Only `rx_s`, the synchronizer output, is used downstream.
- Tick generator: `DIV = CLK_FREQ/(BAUD*OVERSAMPLE)`, integer-truncated; 651 at the defaults. It emits a 1-cycle `tick`. It is restarted (count = 0) on entry to START.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP, WAIT_HIGH.
- IDLE: `rx_s` = 0 → START.
- START: after `OVERSAMPLE/2` ticks, sample `rx_s`.
  - 0 → DATA, tick count and bit index cleared.
  - 1 → IDLE. This is a glitch: no output.
- DATA: every `OVERSAMPLE` ticks, shift `rx_s` in, LSB first. After bit index 7 → PARITY or STOP.
- PARITY: after `OVERSAMPLE` ticks, sample and compare with the XOR of the 8 data bits (even parity). Record any mismatch. → STOP.
- STOP: after `OVERSAMPLE` ticks, sample `rx_s`.
  - 1 and no parity error → update `rx_data`, pulse `rx_valid`, decode, → IDLE.
  - 1 with parity error → pulse `frame_err`, → IDLE.
  - 0 → pulse `frame_err`, → WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s` = 1, then → IDLE. Line breaks never generate frames.
- Decode happens only on a good frame:
  - 'U'(0x55) or 'u'(0x75) → `cmd_up`
  - 'D'(0x44) or 'd'(0x64) → `cmd_down`
  - 'L'(0x4C) or 'l'(0x6C) → `cmd_left`
  - 'C'(0x43) or 'c'(0x63) → `cmd_run`
  - 'R'(0x52) or 'r'(0x72) → `cmd_report`
  - Any other byte → `rx_valid` only.
- At most one `cmd_*` is high in any cycle. The `cmd_*` outputs are never high without `rx_valid`.

## Timing
- Reset values: `rx_data` = 0x00; all pulses 0; FSM in IDLE; synchronizer = 1.
- `rx_valid`, `frame_err` and `cmd_*` are registered and high for exactly one `clk` cycle. They assert in the cycle after the stop-bit sample tick.
- Latency from the `rx` falling edge of the start bit to `rx_valid`: 2 sync cycles + (0.5 + 8 + 1)·OVERSAMPLE·DIV cycles ±1, about 9.5 bit times. With parity enabled, add one bit time.
- Back-to-back frames are supported: the STOP → IDLE transition happens mid stop bit, so the next start edge is caught.
- Reset asserted mid-frame: everything clears immediately; no pulse is produced for the partial frame.
- `rx` held low through reset release: the FSM enters START, then frame_err / WAIT_HIGH. No command is produced.

## Configuration
- `UART_CMD_PARITY_EN` defined: an even-parity bit is expected between D7 and stop, and the PARITY state exists. A mismatch gives a `frame_err` pulse and no `rx_valid`.
- Not defined: plain 8N1; PARITY state and parity logic are absent.

## Structure
- Shared package `uart_cmd_pkg` holds:
  - the FSM state enum;
  - the ASCII command constants;
  - the default `OVERSAMPLE`.
- Sub-module `uart_rx_tick_gen` (parameterized divider with restart input) generates `tick`. The FSM, shifter and decoder stay in `uart_cmd_decoder`.

## Test plan
- Send 'U' (0x55) at 9600 baud → `rx_valid` and `cmd_up` each high 1 cycle, `rx_data` = 0x55, about 9.5 bit times after the start edge. Other `cmd_*` stay 0.
- Send "dLcR" back-to-back with no idle gap → four `rx_valid` pulses, with `cmd_down`, `cmd_left`, `cmd_run`, `cmd_report` in that order. No `frame_err`.
- Send 0x41 ('A') → `rx_valid`, `rx_data` = 0x41, no `cmd_*`.
- Send 0x55 with the stop bit forced low, then hold `rx` low for 3 bit times → one `frame_err`, no `rx_valid`, FSM in WAIT_HIGH until `rx` rises. A following 'C' then decodes correctly.
- 0.3-bit-time low glitch on idle `rx` → no outputs; FSM returns to IDLE.
- Assert reset during DATA bit 4 of 'U', release it, then send 'D' → no `cmd_up`; `cmd_down` fires and `rx_data` = 0x44. With `UART_CMD_PARITY_EN`, 'U' with a wrong parity bit → `frame_err` only.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared FSM encoding, ASCII command constants and decode helper for uart_cmd_decoder.
// UART_CMD_PARITY_EN adds the PARITY state to the encoding.
package uart_cmd_pkg;

    localparam int OVERSAMPLE_DEFAULT = 16;

    localparam logic [7:0] ASCII_UP_UC     = 8'h55;
    localparam logic [7:0] ASCII_UP_LC     = 8'h75;
    localparam logic [7:0] ASCII_DOWN_UC   = 8'h44;
    localparam logic [7:0] ASCII_DOWN_LC   = 8'h64;
    localparam logic [7:0] ASCII_LEFT_UC   = 8'h4C;
    localparam logic [7:0] ASCII_LEFT_LC   = 8'h6C;
    localparam logic [7:0] ASCII_RUN_UC    = 8'h43;
    localparam logic [7:0] ASCII_RUN_LC    = 8'h63;
    localparam logic [7:0] ASCII_REPORT_UC = 8'h52;
    localparam logic [7:0] ASCII_REPORT_LC = 8'h72;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
`ifdef UART_CMD_PARITY_EN
        ST_PARITY    = 3'd3,
`endif
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } state_e;

    typedef struct packed {
        logic report;
        logic run;
        logic left;
        logic down;
        logic up;
    } cmd_t;

    function automatic cmd_t decode_cmd(input logic [7:0] b);
        cmd_t c;
        c = '0;
        case (b)
            ASCII_UP_UC,     ASCII_UP_LC:     c.up     = 1'b1;
            ASCII_DOWN_UC,   ASCII_DOWN_LC:   c.down   = 1'b1;
            ASCII_LEFT_UC,   ASCII_LEFT_LC:   c.left   = 1'b1;
            ASCII_RUN_UC,    ASCII_RUN_LC:    c.run    = 1'b1;
            ASCII_REPORT_UC, ASCII_REPORT_LC: c.report = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator: down-counter reloaded with DIV-1, one-cycle tick at terminal count.
// restart reloads the counter so the first tick lands DIV cycles later.
module uart_rx_tick_gen #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LOAD = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (restart) begin
            cnt_d = LOAD;
        end else if (cnt_q == '0) begin
            cnt_d = LOAD;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= LOAD;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// 8N1 UART receiver that turns single ASCII characters into one-cycle command pulses.
// Define UART_CMD_PARITY_EN to expect an even-parity bit between D7 and stop.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | line idle, waiting for rx_s low
// START     | counting to mid start bit; high there means glitch
// DATA      | sampling D0..D7 mid-bit, LSB first
// PARITY    | sampling even-parity bit (UART_CMD_PARITY_EN only)
// STOP      | sampling stop bit; emit rx_valid/cmd or frame_err
// WAIT_HIGH | stop bit was low (break); wait for line to return high
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       cmd_up,
    output logic       cmd_down,
    output logic       cmd_left,
    output logic       cmd_run,
    output logic       cmd_report
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int CW  = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

    logic rx_meta_q, rx_s_q;
    logic rx_s;
    logic tick, restart;

    state_e        state_q, state_d;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;
    cmd_t          cmd_q, cmd_d;
`ifdef UART_CMD_PARITY_EN
    logic          par_err_q, par_err_d;
`endif

    // Synchronizer flops reset high so a released reset never looks like a start edge by itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign rx_s = rx_s_q;

    uart_rx_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        cmd_d       = '0;
        restart     = 1'b0;
`ifdef UART_CMD_PARITY_EN
        par_err_d   = par_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d    = ST_START;
                    tick_cnt_d = '0;
                    restart    = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (tick_cnt_q == HALF_LAST) begin
                        tick_cnt_d = '0;
                        bit_idx_d  = '0;
                        state_d    = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + CW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s, shift_q[7:1]};
                        bit_idx_d  = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_CMD_PARITY_EN
                            state_d   = ST_PARITY;
                            par_err_d = 1'b0;
`else
                            state_d   = ST_STOP;
`endif
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + CW'(1);
                    end
                end
            end
`ifdef UART_CMD_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        par_err_d  = (rx_s != ^shift_q);
                        state_d    = ST_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + CW'(1);
                    end
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        if (!rx_s) begin
                            frame_err_d = 1'b1;
                            state_d     = ST_WAIT_HIGH;
`ifdef UART_CMD_PARITY_EN
                        end else if (par_err_q) begin
                            frame_err_d = 1'b1;
                            state_d     = ST_IDLE;
`endif
                        end else begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            cmd_d      = decode_cmd(shift_q);
                            state_d    = ST_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + CW'(1);
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            cmd_q       <= '0;
`ifdef UART_CMD_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            cmd_q       <= cmd_d;
`ifdef UART_CMD_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign cmd_up     = cmd_q.up;
    assign cmd_down   = cmd_q.down;
    assign cmd_left   = cmd_q.left;
    assign cmd_run    = cmd_q.run;
    assign cmd_report = cmd_q.report;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: vector table, directed corner sequences, random frames.
// Build with UART_CMD_PARITY_EN to exercise the parity variant.
module tb_uart_cmd_decoder;

    localparam int CLK_FREQ = 614_400;
    localparam int BAUD     = 9600;
    localparam int OS       = 16;
    localparam int DIV      = CLK_FREQ / (BAUD * OS);
    localparam int BIT      = OS * DIV;
`ifdef UART_CMD_PARITY_EN
    localparam int LAT_EXP  = 2 + (OS / 2 + 8 * OS + OS + OS) * DIV;
`else
    localparam int LAT_EXP  = 2 + (OS / 2 + 8 * OS + OS) * DIV;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err;
    logic       cmd_up, cmd_down, cmd_left, cmd_run, cmd_report;
    logic [4:0] cmd_vec;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    bit flip_parity = 1'b0;
    logic [7:0] last_good = 8'h00;

    typedef struct {
        bit         v;
        bit         fe;
        logic [7:0] d;
        logic [4:0] c;
        int         at;
    } ev_t;

    typedef struct {
        logic [7:0] d;
        bit         stop;
        bit         exp_v;
        bit         exp_fe;
        logic [4:0] exp_c;
    } vec_t;

    ev_t  evq[$];
    ev_t  mon_e;
    vec_t tbl[11];

    uart_cmd_decoder #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .cmd_up     (cmd_up),
        .cmd_down   (cmd_down),
        .cmd_left   (cmd_left),
        .cmd_run    (cmd_run),
        .cmd_report (cmd_report)
    );

    assign cmd_vec = {cmd_report, cmd_run, cmd_left, cmd_down, cmd_up};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: logs every output event and checks the command invariants as they occur.
    always @(negedge clk) begin
        if (reset && (rx_valid || frame_err || cmd_vec != 5'b0)) begin
            mon_e.v  = rx_valid;
            mon_e.fe = frame_err;
            mon_e.d  = rx_data;
            mon_e.c  = cmd_vec;
            mon_e.at = cyc;
            evq.push_back(mon_e);
            if (cmd_vec != 5'b0) begin
                checks++;
                if (!rx_valid || $countones(cmd_vec) != 1) begin
                    failures++;
                    $display("FAIL cmd_invariant: cmd=%b rx_valid=%b, required one-hot cmd with rx_valid=1",
                             cmd_vec, rx_valid);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
        $fatal(1, "watchdog");
    end

    // Command model: a byte is a command iff it matches one of "UDLCR" ignoring ASCII case.
    function automatic logic [4:0] model_cmd(input logic [7:0] b);
        string letters;
        letters = "UDLCR";
        for (int i = 0; i < 5; i++) begin
            if ((b | 8'h20) == (8'(letters[i]) | 8'h20)) return 5'b1 << i;
        end
        return 5'b0;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_bit);
        start_cyc = cyc;
        rx = 1'b0;
        wait_cycles(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(BIT);
        end
`ifdef UART_CMD_PARITY_EN
        rx = (^b) ^ flip_parity;
        wait_cycles(BIT);
`endif
        rx = stop_bit;
        wait_cycles(BIT);
    endtask

    task automatic compare_ev(input string name, input ev_t e, input bit v, input bit fe,
                              input logic [7:0] d, input logic [4:0] c);
        checks++;
        if (e.v !== v || e.fe !== fe || e.d !== d || e.c !== c) begin
            failures++;
            $display("FAIL %s: got valid=%b ferr=%b data=%h cmd=%b, required valid=%b ferr=%b data=%h cmd=%b",
                     name, e.v, e.fe, e.d, e.c, v, fe, d, c);
        end
    endtask

    task automatic expect_none(input string name);
        checks++;
        if (evq.size() != 0) begin
            failures++;
            $display("FAIL %s: got %0d output pulses, required 0", name, evq.size());
        end
        evq.delete();
    endtask

    task automatic expect_one(input string name, input bit v, input bit fe,
                              input logic [7:0] d, input logic [4:0] c);
        checks++;
        if (evq.size() != 1) begin
            failures++;
            $display("FAIL %s: got %0d output events, required 1", name, evq.size());
        end
        if (evq.size() != 0) compare_ev(name, evq[0], v, fe, d, c);
        evq.delete();
    endtask

    // Sends a frame and checks it against the model; a low stop bit is followed by idle high.
    task automatic model_frame(input string name, input logic [7:0] b, input bit stop_bit);
        bit good;
        send_frame(b, stop_bit);
        if (!stop_bit) begin
            rx = 1'b1;
            wait_cycles(BIT);
        end
        good = stop_bit && !flip_parity;
        if (good) last_good = b;
        expect_one(name, good, !good, last_good, good ? model_cmd(b) : 5'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        wait_cycles(4);
        reset = 1'b1;
        last_good = 8'h00;
        evq.delete();
    endtask

    initial begin
        int lat;
        logic [7:0] rb;
        bit rstop;
        string word;

        tbl[0]  = '{8'h55, 1'b1, 1'b1, 1'b0, 5'b00001};
        tbl[1]  = '{8'h41, 1'b1, 1'b1, 1'b0, 5'b00000};
        tbl[2]  = '{8'h75, 1'b1, 1'b1, 1'b0, 5'b00001};
        tbl[3]  = '{8'h72, 1'b1, 1'b1, 1'b0, 5'b10000};
        tbl[4]  = '{8'h44, 1'b1, 1'b1, 1'b0, 5'b00010};
        tbl[5]  = '{8'h63, 1'b1, 1'b1, 1'b0, 5'b01000};
        tbl[6]  = '{8'h6C, 1'b1, 1'b1, 1'b0, 5'b00100};
        tbl[7]  = '{8'hD5, 1'b1, 1'b1, 1'b0, 5'b00000};
        tbl[8]  = '{8'h52, 1'b0, 1'b0, 1'b1, 5'b00000};
        tbl[9]  = '{8'h00, 1'b1, 1'b1, 1'b0, 5'b00000};
        tbl[10] = '{8'hFF, 1'b1, 1'b1, 1'b0, 5'b00000};

        // Reset values
        wait_cycles(3);
        checks++;
        if (rx_data !== 8'h00 || rx_valid !== 1'b0 || frame_err !== 1'b0 || cmd_vec !== 5'b0) begin
            failures++;
            $display("FAIL reset_values: got data=%h valid=%b ferr=%b cmd=%b, required 00 0 0 00000",
                     rx_data, rx_valid, frame_err, cmd_vec);
        end
        reset = 1'b1;
        wait_cycles(2 * BIT);
        expect_none("idle_after_reset");

        // 'U' with latency measurement
        send_frame(8'h55, 1'b1);
        checks++;
        lat = (evq.size() != 0) ? evq[0].at - start_cyc : -1;
        if (lat < LAT_EXP - 2 || lat > LAT_EXP + 2) begin
            failures++;
            $display("FAIL latency_U: got %0d cycles, required %0d +/-2", lat, LAT_EXP);
        end
        last_good = 8'h55;
        expect_one("send_U", 1'b1, 1'b0, 8'h55, 5'b00001);

        // Table vectors
        for (int i = 0; i < 11; i++) begin
            send_frame(tbl[i].d, tbl[i].stop);
            if (!tbl[i].stop) begin
                rx = 1'b1;
                wait_cycles(BIT);
            end
            if (tbl[i].exp_v) last_good = tbl[i].d;
            $sformat(word, "table_%0d", i);
            expect_one(word, tbl[i].exp_v, tbl[i].exp_fe, last_good, tbl[i].exp_c);
        end

        // "dLcR" back-to-back with no idle gap
        send_frame(8'h64, 1'b1);
        send_frame(8'h4C, 1'b1);
        send_frame(8'h63, 1'b1);
        send_frame(8'h52, 1'b1);
        wait_cycles(BIT);
        checks++;
        if (evq.size() != 4) begin
            failures++;
            $display("FAIL b2b_count: got %0d events, required 4", evq.size());
        end
        if (evq.size() > 0) compare_ev("b2b_d", evq[0], 1'b1, 1'b0, 8'h64, 5'b00010);
        if (evq.size() > 1) compare_ev("b2b_L", evq[1], 1'b1, 1'b0, 8'h4C, 5'b00100);
        if (evq.size() > 2) compare_ev("b2b_c", evq[2], 1'b1, 1'b0, 8'h63, 5'b01000);
        if (evq.size() > 3) compare_ev("b2b_R", evq[3], 1'b1, 1'b0, 8'h52, 5'b10000);
        evq.delete();
        last_good = 8'h52;

        // Stop bit low, line held low 3 more bit times, then 'C'
        send_frame(8'h55, 1'b0);
        wait_cycles(3 * BIT);
        expect_one("break_ferr", 1'b0, 1'b1, 8'h52, 5'b00000);
        rx = 1'b1;
        wait_cycles(BIT);
        model_frame("after_break_C", 8'h43, 1'b1);

        // 0.3-bit glitch on idle line, then a normal frame
        rx = 1'b0;
        wait_cycles(BIT * 3 / 10);
        rx = 1'b1;
        wait_cycles(2 * BIT);
        expect_none("glitch");
        model_frame("after_glitch_l", 8'h6C, 1'b1);

        // Reset during D4 of 'U', then 'D'
        rx = 1'b0;
        wait_cycles(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = 1'(8'h55 >> i);
            wait_cycles(BIT);
        end
        rx = 1'b1;
        wait_cycles(BIT / 2);
        reset = 1'b0;
        wait_cycles(2);
        checks++;
        if (rx_data !== 8'h00) begin
            failures++;
            $display("FAIL midframe_reset_data: got %h, required 00", rx_data);
        end
        wait_cycles(2);
        reset = 1'b1;
        last_good = 8'h00;
        wait_cycles(2 * BIT);
        expect_none("midframe_reset_no_pulse");
        model_frame("after_reset_D", 8'h44, 1'b1);

        // rx held low through reset release
        rx = 1'b0;
        do_reset();
        wait_cycles(12 * BIT);
        expect_one("low_through_reset", 1'b0, 1'b1, 8'h00, 5'b00000);
        rx = 1'b1;
        wait_cycles(BIT);
        model_frame("after_low_reset_R", 8'h72, 1'b1);

`ifdef UART_CMD_PARITY_EN
        flip_parity = 1'b1;
        model_frame("parity_bad_U", 8'h55, 1'b1);
        flip_parity = 1'b0;
        model_frame("parity_good_U", 8'h55, 1'b1);
`endif

        // Randomized frames against the model
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 9))
                    0: rb = 8'h55; 1: rb = 8'h75; 2: rb = 8'h44; 3: rb = 8'h64; 4: rb = 8'h4C;
                    5: rb = 8'h6C; 6: rb = 8'h43; 7: rb = 8'h63; 8: rb = 8'h52; default: rb = 8'h72;
                endcase
            end else begin
                rb = 8'($urandom);
            end
            rstop = ($urandom_range(0, 9) != 0);
            $sformat(word, "random_%0d_%h", n, rb);
            model_frame(word, rb, rstop);
            if ($urandom_range(0, 1) == 0) wait_cycles($urandom_range(1, BIT));
        end

        checks++;
        if (rx_data !== last_good) begin
            failures++;
            $display("FAIL final_rx_data: got %h, required %h", rx_data, last_good);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
